// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and step classifier for the ring monitor
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_e;

    typedef enum logic [2:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_JUMP,
        STEP_ILLEGAL
    } step_e;

    // Classifies a move from stored position p to new position n on a ring of 'width' bits.
    function automatic step_e step_class(
        input int unsigned n,
        input int unsigned p,
        input logic        legal,
        input int unsigned width
    );
        if (!legal) begin
            return STEP_ILLEGAL;
        end
        if (n == p) begin
            return STEP_HOLD;
        end
        if (n == ((p + 1) % width)) begin
            return STEP_UP;
        end
        if (n == ((p + width - 1) % width)) begin
            return STEP_DOWN;
        end
        return STEP_JUMP;
    endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// rtl/ring_onehot_decode.sv - one-hot to binary decoder with legality flag
module ring_onehot_decode #(
    parameter  int WIDTH = 8,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] Ring,
    output logic [IW-1:0]    Index,
    output logic             Legal
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] ones;
    logic [IW-1:0] idx;

    // The OR-accumulated index is only meaningful when exactly one bit is set.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (Ring[i]) begin
                idx  = idx | IW'(i);
                ones = ones + CW'(1);
            end
        end
        Index = idx;
        Legal = (ones == CW'(1));
    end

endmodule

// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - ring bus monitor: decode, step classification, lock FSM, error counting
module ring_monitor
    import ring_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int LOCK_COUNT = 4,
    parameter  int ERR_W      = 8,
    localparam int IW         = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Ring,
    input  logic             LoadSeen,
    output logic [IW-1:0]    Index,
    output logic             IndexOk,
    output logic             Dir,
    output logic             Locked,
    output logic             Error,
    output logic [ERR_W-1:0] ErrCount
);

    localparam int GC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [GC_W-1:0] GC_ONE  = GC_W'(1);
    localparam logic [GC_W-1:0] GC_FULL = GC_W'(LOCK_COUNT);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(LOCK_COUNT - 1);

    state_e            state_q, state_d;
    logic [GC_W-1:0]   gc_q, gc_d;
    logic [IW-1:0]     index_q, index_d;
    logic              index_ok_q, index_ok_d;
    logic              dir_q, dir_d;
    logic              error_d;
    logic              error_q;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic [IW-1:0]     dec_index;
    logic              dec_legal;
    step_e             step;

    ring_onehot_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .Ring  (Ring),
        .Index (dec_index),
        .Legal (dec_legal)
    );

    assign step = step_class(int'(dec_index), int'(index_q), dec_legal, WIDTH);

    always_comb begin
        state_d    = state_q;
        gc_d       = gc_q;
        index_d    = index_q;
        index_ok_d = index_ok_q;
        dir_d      = dir_q;
        error_d    = 1'b0;

        if (Valid) begin
            index_ok_d = dec_legal;
            case (state_q)
                HUNT: begin
                    if (dec_legal) begin
                        index_d = dec_index;
                        gc_d    = GC_ONE;
                        state_d = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                    end
                end
                CHECK: begin
                    case (step)
                        STEP_HOLD, STEP_UP, STEP_DOWN: begin
                            index_d = dec_index;
                            if (step == STEP_UP)   dir_d = 1'b1;
                            if (step == STEP_DOWN) dir_d = 1'b0;
                            if (gc_q >= GC_LAST) begin
                                gc_d    = GC_FULL;
                                state_d = LOCKED;
                            end else begin
                                gc_d = gc_q + GC_ONE;
                            end
                        end
                        STEP_JUMP: begin
                            // Jumps restart qualification regardless of LoadSeen.
                            index_d = dec_index;
                            gc_d    = GC_ONE;
                            state_d = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                        end
                        default: begin
                            gc_d    = '0;
                            state_d = HUNT;
                        end
                    endcase
                end
                LOCKED: begin
                    case (step)
                        STEP_HOLD, STEP_UP, STEP_DOWN: begin
                            index_d = dec_index;
                            if (step == STEP_UP)   dir_d = 1'b1;
                            if (step == STEP_DOWN) dir_d = 1'b0;
                        end
                        STEP_JUMP: begin
                            index_d = dec_index;
                            if (!LoadSeen) begin
                                error_d = 1'b1;
                                gc_d    = GC_ONE;
                                state_d = CHECK;
                            end
                        end
                        default: begin
                            error_d = 1'b1;
                            gc_d    = '0;
                            state_d = HUNT;
                        end
                    endcase
                end
                default: begin
                    gc_d    = '0;
                    state_d = HUNT;
                end
            endcase
        end

        // Saturating count; the Error pulse itself is never suppressed.
        err_cnt_d = err_cnt_q;
        if (error_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= HUNT;
            gc_q       <= '0;
            index_q    <= '0;
            index_ok_q <= 1'b0;
            dir_q      <= 1'b1;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gc_q       <= gc_d;
            index_q    <= index_d;
            index_ok_q <= index_ok_d;
            dir_q      <= dir_d;
            error_q    <= error_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign Index    = index_q;
    assign IndexOk  = index_ok_q;
    assign Dir      = dir_q;
    assign Locked   = (state_q == LOCKED);
    assign Error    = error_q;
    assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_ring_monitor.sv
// tb/tb_ring_monitor.sv - self-checking bench for ring_monitor against a behavioural model
module tb_ring_monitor;

    localparam int W  = 8;
    localparam int LC = 4;

    localparam int M_HUNT   = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Valid;
    logic [7:0] Ring;
    logic       LoadSeen;

    logic [2:0] Index, Index2;
    logic       IndexOk, IndexOk2;
    logic       Dir, Dir2;
    logic       Locked, Locked2;
    logic       Error, Error2;
    logic [7:0] ErrCount;
    logic [1:0] ErrCount2;

    int n_vec  = 0;
    int n_miss = 0;
    int pulses2 = 0;

    int m_state, m_gc, m_index, m_dir, m_ok, m_err, m_cnt8, m_cnt2;

    always #5 Clock = ~Clock;

    ring_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_W(8)) u_dut (
        .Clock(Clock), .Reset(Reset), .Valid(Valid), .Ring(Ring), .LoadSeen(LoadSeen),
        .Index(Index), .IndexOk(IndexOk), .Dir(Dir), .Locked(Locked),
        .Error(Error), .ErrCount(ErrCount)
    );

    ring_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_W(2)) u_dut_e2 (
        .Clock(Clock), .Reset(Reset), .Valid(Valid), .Ring(Ring), .LoadSeen(LoadSeen),
        .Index(Index2), .IndexOk(IndexOk2), .Dir(Dir2), .Locked(Locked2),
        .Error(Error2), .ErrCount(ErrCount2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_HUNT; m_gc = 0; m_index = 0; m_dir = 1; m_ok = 0;
        m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_error();
        m_err  = 1;
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    endtask

    task automatic model_step(input logic v, input logic [7:0] r, input logic l, input logic rst);
        int n, diff;
        bit legal;
        if (rst) begin
            model_reset();
            return;
        end
        m_err = 0;
        if (!v) return;
        legal = ($countones(r) == 1);
        n = 0;
        for (int i = 0; i < W; i++) if (r[i]) n = i;
        m_ok = legal;
        diff = (n - m_index + W) % W;
        if (m_state == M_HUNT) begin
            if (legal) begin
                m_index = n; m_gc = 1;
                m_state = (LC == 1) ? M_LOCKED : M_CHECK;
            end
        end else if (!legal) begin
            if (m_state == M_LOCKED) model_error();
            m_state = M_HUNT; m_gc = 0;
        end else if (diff == 0 || diff == 1 || diff == W - 1) begin
            m_index = n;
            if (diff == 1) m_dir = 1;
            if (diff == W - 1) m_dir = 0;
            if (m_state == M_CHECK) begin
                m_gc++;
                if (m_gc >= LC) begin m_gc = LC; m_state = M_LOCKED; end
            end
        end else begin
            m_index = n;
            if (m_state == M_CHECK) begin
                m_gc = 1;
            end else if (!l) begin
                model_error();
                m_state = M_CHECK; m_gc = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("index",      Index,     m_index);
        check("index_ok",   IndexOk,   m_ok);
        check("dir",        Dir,       m_dir);
        check("locked",     Locked,    m_state == M_LOCKED);
        check("error",      Error,     m_err);
        check("err_count",  ErrCount,  m_cnt8);
        check("index_e2",   Index2,    m_index);
        check("locked_e2",  Locked2,   m_state == M_LOCKED);
        check("error_e2",   Error2,    m_err);
        check("err_cnt_e2", ErrCount2, m_cnt2);
        check("dir_e2",     Dir2,      m_dir);
        check("ok_e2",      IndexOk2,  m_ok);
    endtask

    task automatic apply(input logic v, input logic [7:0] r, input logic l, input logic rst);
        Reset = rst; Valid = v; Ring = r; LoadSeen = l;
        @(posedge Clock);
        model_step(v, r, l, rst);
        #1;
        compare_all();
        if (Error2 === 1'b1) pulses2++;
    endtask

    task automatic lock_at(input int idx);
        logic [7:0] r;
        r = 8'h01 << idx;
        for (int i = 0; i < LC; i++) apply(1'b1, r, 1'b1, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_index"},  Index,    0);
        check({tag, "_ok"},     IndexOk,  0);
        check({tag, "_dir"},    Dir,      1);
        check({tag, "_locked"}, Locked,   0);
        check({tag, "_error"},  Error,    0);
        check({tag, "_cnt"},    ErrCount, 0);
        check({tag, "_cnt2"},   ErrCount2, 0);
    endtask

    initial begin
        logic [7:0] r;
        int mode, d;
        Reset = 1'b1; Valid = 1'b0; Ring = '0; LoadSeen = 1'b0;
        model_reset();
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        check_reset_values("reset");

        for (int i = 0; i < 4; i++) apply(1'b1, 8'h01 << i, 1'b0, 1'b0);
        check("plan_lock_locked", Locked, 1);
        check("plan_lock_index", Index, 3);
        check("plan_lock_dir", Dir, 1);
        check("plan_lock_nopulse", pulses2, 0);

        for (int i = 4; i < 8; i++) apply(1'b1, 8'h01 << i, 1'b0, 1'b0);
        apply(1'b1, 8'h01, 1'b0, 1'b0);
        check("plan_wrap_up_index", Index, 0);
        apply(1'b1, 8'h80, 1'b0, 1'b0);
        check("plan_wrap_down_index", Index, 7);
        check("plan_wrap_down_dir", Dir, 0);
        apply(1'b1, 8'h40, 1'b0, 1'b0);
        check("plan_down_index", Index, 6);
        check("plan_down_locked", Locked, 1);
        check("plan_down_nopulse", pulses2, 0);

        apply(1'b1, 8'h20, 1'b0, 1'b0);
        apply(1'b1, 8'h10, 1'b0, 1'b0);
        apply(1'b1, 8'h08, 1'b0, 1'b0);
        apply(1'b1, 8'h04, 1'b0, 1'b0);
        apply(1'b1, 8'h20, 1'b0, 1'b0);
        check("plan_jump_error", Error, 1);
        check("plan_jump_cnt", ErrCount, 1);
        check("plan_jump_index", Index, 5);
        check("plan_jump_locked", Locked, 0);

        lock_at(2);
        apply(1'b1, 8'h20, 1'b1, 1'b0);
        check("plan_load_error", Error, 0);
        check("plan_load_locked", Locked, 1);
        check("plan_load_index", Index, 5);

        apply(1'b1, 8'h00, 1'b0, 1'b0);
        check("plan_zero_error", Error, 1);
        check("plan_zero_ok", IndexOk, 0);
        check("plan_zero_locked", Locked, 0);
        check("plan_zero_index", Index, 5);
        lock_at(5);
        apply(1'b1, 8'h03, 1'b0, 1'b0);
        check("plan_multi_error", Error, 1);
        check("plan_multi_index", Index, 5);

        lock_at(5);
        apply(1'b1, 8'h00, 1'b0, 1'b0);
        lock_at(5);
        apply(1'b1, 8'hFF, 1'b0, 1'b0);
        check("plan_sat_cnt2", ErrCount2, 3);
        check("plan_sat_cnt8", ErrCount, 5);
        check("plan_sat_pulses", pulses2, 5);

        apply(1'b1, 8'h10, 1'b0, 1'b1);
        check_reset_values("plan_rst_valid");

        for (int k = 0; k < 3000; k++) begin
            mode = $urandom_range(0, 99);
            if (mode < 45) begin
                d = $urandom_range(0, 2) - 1;
                r = 8'h01 << ((m_index + d + W) % W);
            end else if (mode < 65) begin
                r = 8'h01 << $urandom_range(0, 7);
            end else if (mode < 80) begin
                r = 8'($urandom_range(0, 255));
            end else if (mode < 85) begin
                r = 8'h00;
            end else begin
                r = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
            end
            apply($urandom_range(0, 9) != 0, r, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ring_monitor.md
# ring_monitor

Receive-side companion to the ring counter. It samples an external 8-bit one-hot ring bus, decodes the active bit position to a binary index, and classifies every step as hold, up, down, jump or illegal. A lock state machine declares the stream trustworthy, then flags and counts protocol errors. It sits at the consumer end of a ring-counter output, for example a board-level checker or a downstream sequencer that needs the position as binary.

## Interface
- `WIDTH`, default 8: ring width in bits; must be ≥ 3. `IW = $clog2(WIDTH)`.
- `LOCK_COUNT`, default 4: consecutive good samples needed to reach LOCKED (≥ 1).
- `ERR_W`, default 8: width of the error counter.
- `Clock`  in  1: single clock; all logic on its rising edge.
- `Reset`  in  1: synchronous, active-high.
- `Valid`  in  1: `Ring` is sampled on this cycle.
- `Ring`  in  WIDTH: observed ring bus.
- `LoadSeen`  in  1: qualifies a sample with `Valid`; the source was loaded, so a jump is legitimate.
- `Index`  out  IW: binary position of the last legal sample.
- `IndexOk`  out  1: the last sample was legal one-hot.
- `Dir`  out  1: direction of the last up/down step; 1 = up, 0 = down.
- `Locked`  out  1: the state machine is in LOCKED.
- `Error`  out  1: one-cycle pulse on each detected error.
- `ErrCount`  out  ERR_W: saturating error count.

## Operation
- Legal sample: exactly one bit of `Ring` is set. All-zero and multi-hot samples are illegal.
- Step classification, with n = new index and p = stored `Index`:
  - n == p: HOLD.
  - n == (p+1) mod WIDTH: UP.
  - n == (p−1) mod WIDTH: DOWN.
  - otherwise: JUMP.
- Wrap-around: p=WIDTH−1 → n=0 is UP; p=0 → n=WIDTH−1 is DOWN.
- A cycle with `Valid`=0 changes no state. `Error` returns to 0.
- States: HUNT, CHECK, LOCKED. The good counter `gc` ranges 0..LOCK_COUNT.
- HUNT:
  - Legal sample: store `Index`, set `gc`=1. If LOCK_COUNT=1 go to LOCKED, else go to CHECK.
  - Illegal sample: stay in HUNT.
- CHECK:
  - HOLD, UP or DOWN: increment `gc`. UP/DOWN also updates `Dir`. When `gc` reaches LOCK_COUNT, go to LOCKED.
  - JUMP: store the new index and set `gc`=1. A jump with `LoadSeen` is treated the same way.
  - Illegal sample: go to HUNT, with no error flagged.
- LOCKED:
  - HOLD, UP or DOWN: update `Index` (and `Dir` for UP/DOWN); stay in LOCKED. A direction reversal is legal.
  - JUMP with `LoadSeen`=1: store the new index, stay in LOCKED, keep `Dir`, flag no error.
  - JUMP with `LoadSeen`=0: raise `Error`, increment `ErrCount`, store the new index, go to CHECK with `gc`=1.
  - Illegal sample: raise `Error`, increment `ErrCount`, go to HUNT. `Index` holds its value.
- `IndexOk` tracks the legality of the most recent `Valid` sample in every state.
- `ErrCount` saturates at 2^ERR_W−1. `Error` still pulses while saturated.
- `LoadSeen` is ignored in HUNT and on non-JUMP samples.

## Timing
- All outputs are registered. A sample taken at edge k is reflected on the outputs after edge k (1-cycle latency).
- Reset values:
  - `Index`=0, `IndexOk`=0, `Dir`=1, `Locked`=0, `Error`=0, `ErrCount`=0.
  - State HUNT, `gc`=0.
- `Reset` has priority over `Valid` in the same cycle; the sample is discarded.
- Reset mid-LOCKED: the next cycle shows reset values. `ErrCount` is cleared.
- Back-to-back `Valid` samples are supported at one sample per clock.

## Structure
- Package `ring_pkg`:
  - State enum `{HUNT, CHECK, LOCKED}`.
  - Step enum `{STEP_HOLD, STEP_UP, STEP_DOWN, STEP_JUMP, STEP_ILLEGAL}`.
  - Function computing the step class from `(n, p, legal)`.
- Sub-module `ring_onehot_decode`: purely combinational, parameterised by WIDTH. Maps `Ring` to index and `legal` (popcount == 1).
- Top level: the decoder, the step classifier, the FSM, `gc`, and the output registers.

## Test plan
- Reset, then feed samples with `Valid`=1 of 0x01, 0x02, 0x04, 0x08 (LOCK_COUNT=4) → `Locked`=1 after the 4th sample, `Index`=3, `Dir`=1, `Error` never asserted.
- While locked at `Index`=0, feed 0x80 then 0x40 → `Index` 7 then 6, `Dir`=0, no `Error`.
- While locked at `Index`=2, feed 0x20 with `LoadSeen`=0 → `Error` pulse, `ErrCount`=1, `Index`=5, `Locked`=0. Repeat the same step with `LoadSeen`=1 from locked → no `Error`, `Locked` stays 1.
- While locked, feed 0x00 then 0x03 → two `Error` pulses across the two samples, `IndexOk`=0, state HUNT, `Index` held.
- With ERR_W=2, force 5 errors → `ErrCount` stays at 3 and `Error` pulses 5 times. Then assert `Reset` together with `Valid` and `Ring`=0x10 → all outputs return to reset values and `Index`=0.
